hex_history_display: RTL and testbench

//  Downstream of the nibble ring-buffer stage: consumes its 4-bit data_out and drives the four DE0 seven-segment digits.

---
 rtl/hex_history_display_pkg.sv | 37 +++
 rtl/hex_history_display_hex7seg.sv | 15 +
 rtl/hex_history_display.sv | 146 ++++++++++++++
 tb/tb_hex_history_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hex_history_display_pkg.sv
// Shared constants for the hex history display: segment encoding,
// blank pattern and blink FSM state encoding.
package hex_history_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_BLINK  = 1'b1
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_history_display_hex7seg.sv
// Nibble to active-low seven-segment decoder, purely combinational.
// One instance per displayed digit.
module hex7seg
    import hex_history_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = seg_decode(value);
    end

endmodule

// File: rtl/hex_history_display.sv
// Four-digit history of distinct nibble values with a blinking newest
// digit; digits without a captured value stay blank.
module hex_history_display
    import hex_history_display_pkg::*;
#(
    parameter int BLINK_DIV    = 25_000_000,
    parameter int BLINK_HALVES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       clr,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [2:0] depth
);

    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HLV_W = $clog2(BLINK_HALVES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [HLV_W-1:0] HLV_LAST = HLV_W'(BLINK_HALVES - 1);

    logic [3:0]       last_reg;
    logic [3:0]       hist [4];
    logic [2:0]       depth_reg;
    logic             change;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [HLV_W-1:0] halves, halves_nxt;
    logic             phase_on, phase_nxt;

    logic [6:0]       seg [4];
    logic [6:0]       digit [4];

    assign change = (data_in != last_reg) && !clr;
    assign depth  = depth_reg;

    // History shift register, last-seen value and fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg  <= 4'h0;
            hist[0]   <= 4'h0;
            hist[1]   <= 4'h0;
            hist[2]   <= 4'h0;
            hist[3]   <= 4'h0;
            depth_reg <= 3'd0;
        end else if (clr) begin
            last_reg  <= data_in;
            hist[0]   <= 4'h0;
            hist[1]   <= 4'h0;
            hist[2]   <= 4'h0;
            hist[3]   <= 4'h0;
            depth_reg <= 3'd0;
        end else if (change) begin
            last_reg  <= data_in;
            hist[0]   <= data_in;
            hist[1]   <= hist[0];
            hist[2]   <= hist[1];
            hist[3]   <= hist[2];
            if (depth_reg != 3'd4) begin
                depth_reg <= depth_reg + 3'd1;
            end
        end
    end

    // Blink FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STEADY;
            div      <= '0;
            halves   <= '0;
            phase_on <= 1'b1;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            halves   <= halves_nxt;
            phase_on <= phase_nxt;
        end
    end

    // Blink FSM next-state: a change (re)starts blinking, clr stops it
    always_comb begin
        state_nxt  = state;
        div_nxt    = div;
        halves_nxt = halves;
        phase_nxt  = phase_on;
        if (clr) begin
            state_nxt  = ST_STEADY;
            div_nxt    = '0;
            halves_nxt = '0;
            phase_nxt  = 1'b1;
        end else if (change) begin
            state_nxt  = ST_BLINK;
            div_nxt    = '0;
            halves_nxt = '0;
            phase_nxt  = 1'b1;
        end else begin
            case (state)
                ST_BLINK: begin
                    if (div == DIV_LAST) begin
                        div_nxt = '0;
                        if (halves == HLV_LAST) begin
                            state_nxt  = ST_STEADY;
                            halves_nxt = '0;
                            phase_nxt  = 1'b1;
                        end else begin
                            halves_nxt = halves + 1'b1;
                            phase_nxt  = !phase_on;
                        end
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_STEADY;
                end
            endcase
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_dec
        hex7seg u_dec (
            .value (hist[k]),
            .seg   (seg[k])
        );
    end

    // Blank digits beyond the fill level, blink only the newest
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            digit[k] = (depth_reg > 3'(k)) ? seg[k] : SEG_BLANK;
        end
        if (state == ST_BLINK && !phase_on) begin
            digit[0] = SEG_BLANK;
        end
    end

    assign hex0 = digit[0];
    assign hex1 = digit[1];
    assign hex2 = digit[2];
    assign hex3 = digit[3];

endmodule

// File: tb/tb_hex_history_display.sv
// Scoreboard bench for hex_history_display: directed scenarios plus
// randomized traffic against a queue-based history model.
module tb_hex_history_display;

    localparam int BDIV = 4;
    localparam int BHLV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_in;
    logic       clr;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [2:0] depth;

    hex_history_display #(
        .BLINK_DIV    (BDIV),
        .BLINK_HALVES (BHLV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .clr     (clr),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .depth   (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][6:0] h;
        logic [2:0]      d;
    } exp_t;

    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: newest value at the front of the queue
    int  m_last = 0;
    int  m_hist [$];
    bit  m_blink = 0;
    int  m_t = 0;

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (k < m_hist.size()) e.h[k] = segtab[m_hist[k]];
            else e.h[k] = 7'h7F;
        end
        if (m_blink && ((m_t / BDIV) % 2 == 1)) e.h[0] = 7'h7F;
        e.d = 3'(m_hist.size());
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the expected post-edge view is queued
    task automatic step(input int d, input bit c, input bit r);
        @(negedge clk);
        data_in = 4'(d);
        clr     = c;
        rst_n   = r;
        if (!r) begin
            m_last = 0;
            m_hist.delete();
            m_blink = 0;
        end else if (c) begin
            m_hist.delete();
            m_last = d;
            m_blink = 0;
        end else if (d != m_last) begin
            m_hist.push_front(d);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
            m_last = d;
            m_blink = 1;
            m_t = 0;
        end else if (m_blink) begin
            m_t++;
            if (m_t >= BHLV * BDIV) m_blink = 0;
        end
        sb.push_back(model_out());
    endtask

    task automatic hold(input int d, input int n);
        step(d, 0, 1);
        for (int i = 1; i < n; i++) step(d, 0, 1);
    endtask

    // Monitor: compare DUT view just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hex0", hex0, e.h[0]);
                check("hex1", hex1, e.h[1]);
                check("hex2", hex2, e.h[2]);
                check("hex3", hex3, e.h[3]);
                check("depth", depth, e.d);
            end
        end
    end

    initial begin
        int v;
        int len;
        rst_n   = 1'b0;
        data_in = 4'h0;
        clr     = 1'b0;
        #1;
        check("rst_hex0", hex0, 7'h7F);
        check("rst_hex3", hex3, 7'h7F);
        check("rst_depth", depth, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        hold(0, 20);
        hold(5, 20);
        hold(3, 20);
        hold(10, 20);
        hold(0, 20);
        hold(7, 20);
        hold(7, 20);
        step(2, 1, 1);
        hold(2, 10);
        hold(4, 20);

        // async reset while the newest digit is in an off phase
        hold(9, 5);
        @(posedge clk);
        #3;
        check("pre_rst_off", hex0, 7'h7F);
        check("pre_rst_depth", depth, 2);
        rst_n = 1'b0;
        #1;
        check("arst_hex0", hex0, 7'h7F);
        check("arst_hex1", hex1, 7'h7F);
        check("arst_hex2", hex2, 7'h7F);
        check("arst_hex3", hex3, 7'h7F);
        check("arst_depth", depth, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        hold(0, 3);

        for (int i = 0; i < 150; i++) begin
            v   = $urandom_range(0, 15);
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 19) == 0) step(v, 1, 1);
            else step(v, 0, 1);
            for (int j = 1; j < len; j++) step(v, 0, 1);
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
